// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and defaults for the memory responder
package mem_pkg;

    localparam int ADDR_W_DEF      = 9;
    localparam int DATA_W_DEF      = 32;
    localparam int WAIT_CYCLES_DEF = 2;
    localparam int CNT_W           = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        HOLD
    } state_t;

    typedef enum logic {
        OP_RD,
        OP_WR
    } op_t;

endpackage

// File: rtl/mem_array.sv
// rtl/mem_array.sv - single-port synchronous RAM with registered read data
module mem_array
    import mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Storage is never reset; only the output register is.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= '0;
        end else if (en && !we) begin
            dout <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - strobe-driven memory responder with configurable wait states
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              Read,
    input  logic              Write,
    input  logic [ADDR_W-1:0] MAR_addr,
    input  logic [DATA_W-1:0] MDR_data,
    output logic [DATA_W-1:0] Mdatain,
    output logic              Mem_ready,
    output logic              busy,
    output logic              err
);

    state_t            state;
    op_t               op;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [CNT_W-1:0]  cnt;
    logic              conflict;
    logic              access;

    assign access = (state == WAIT) && (cnt == '0);
    assign busy   = (state != IDLE);

    // The RAM output register doubles as Mdatain, so it only moves on reads.
    mem_array #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_mem (
        .clk  (clk),
        .rst_n(clr),
        .en   (access),
        .we   (op == OP_WR),
        .addr (addr_q),
        .din  (data_q),
        .dout (Mdatain)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state     <= IDLE;
            op        <= OP_RD;
            addr_q    <= '0;
            data_q    <= '0;
            cnt       <= '0;
            conflict  <= 1'b0;
            Mem_ready <= 1'b0;
            err       <= 1'b0;
        end else begin
            Mem_ready <= 1'b0;
            err       <= 1'b0;
            case (state)
                IDLE: begin
                    if (Read || Write) begin
                        addr_q   <= MAR_addr;
                        data_q   <= MDR_data;
                        op       <= Write ? OP_WR : OP_RD;
                        cnt      <= CNT_W'(WAIT_CYCLES);
                        conflict <= Read && Write;
                        state    <= (Read && Write) ? HOLD : WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        Mem_ready <= 1'b1;
                        state     <= HOLD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HOLD: begin
                    // A conflicting capture reports on the first HOLD edge.
                    err      <= conflict;
                    conflict <= 1'b0;
                    if (!Read && !Write) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboard bench for mem_responder (wait=2 and wait=0 instances)
module tb_mem_responder;

    localparam int LAT0 = 3;
    localparam int LAT1 = 1;

    logic        clk;
    logic        clr  [2];
    logic        rd   [2];
    logic        wr   [2];
    logic [8:0]  addr [2];
    logic [31:0] wdat [2];
    logic [31:0] mdat [2];
    logic        rdy  [2];
    logic        bsy  [2];
    logic        er   [2];

    logic [31:0] model   [2][512];
    logic [31:0] last_rd [2];
    logic [31:0] exp_q [$];

    int total = 0;
    int bad   = 0;

    mem_responder #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(2)) dut0 (
        .clk(clk), .clr(clr[0]), .Read(rd[0]), .Write(wr[0]),
        .MAR_addr(addr[0]), .MDR_data(wdat[0]), .Mdatain(mdat[0]),
        .Mem_ready(rdy[0]), .busy(bsy[0]), .err(er[0])
    );

    mem_responder #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(0)) dut1 (
        .clk(clk), .clr(clr[1]), .Read(rd[1]), .Write(wr[1]),
        .MAR_addr(addr[1]), .MDR_data(wdat[1]), .Mdatain(mdat[1]),
        .Mem_ready(rdy[1]), .busy(bsy[1]), .err(er[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic sb_check(input int d, input string tag);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk(tag, mdat[d], e);
            last_rd[d] = e;
        end
    endtask

    task automatic req(input int d, input bit is_rd, input logic [8:0] a,
                       input logic [31:0] wd, input int lat, input string tag);
        int n;
        @(negedge clk);
        rd[d] = is_rd; wr[d] = !is_rd; addr[d] = a; wdat[d] = wd;
        if (is_rd) exp_q.push_back(model[d][a]);
        else model[d][a] = wd;
        @(negedge clk);
        // Capture edge has passed; scramble inputs to prove they were latched.
        rd[d] = 1'b0; wr[d] = 1'b0;
        addr[d] = 9'($urandom); wdat[d] = $urandom;
        n = 0;
        while (n < 20 && !rdy[d]) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, n, lat);
        if (is_rd) sb_check(d, {tag, "_data"});
        else chk({tag, "_mdat_hold"}, mdat[d], last_rd[d]);
        @(negedge clk);
        chk({tag, "_rdy_pulse"}, 32'(rdy[d]), 32'd0);
        chk({tag, "_idle"}, 32'(bsy[d]), 32'd0);
    endtask

    initial begin
        int pulses;
        for (int d = 0; d < 2; d++) begin
            clr[d] = 1'b0; rd[d] = 1'b0; wr[d] = 1'b0;
            addr[d] = '0; wdat[d] = '0; last_rd[d] = '0;
        end
        #12;
        for (int d = 0; d < 2; d++) begin
            chk("rst_mdat", mdat[d], 32'd0);
            chk("rst_rdy", 32'(rdy[d]), 32'd0);
            chk("rst_busy", 32'(bsy[d]), 32'd0);
            chk("rst_err", 32'(er[d]), 32'd0);
        end
        @(negedge clk);
        clr[0] = 1'b1; clr[1] = 1'b1;

        req(0, 1'b0, 9'd3, 32'h0000_00AA, LAT0, "pre3");
        req(0, 1'b0, 9'd4, 32'h0000_0044, LAT0, "pre4");
        req(0, 1'b0, 9'd5, 32'h1111_1111, LAT0, "pre5");

        req(0, 1'b0, 9'h010, 32'h2891_8000, LAT0, "wr10");
        req(0, 1'b1, 9'h010, 32'h0, LAT0, "rd10");

        // Reset mid-WAIT of a write must abandon it.
        @(negedge clk);
        wr[0] = 1'b1; addr[0] = 9'd5; wdat[0] = 32'hDEAD_BEEF;
        @(negedge clk);
        wr[0] = 1'b0;
        @(negedge clk);
        chk("mid_busy", 32'(bsy[0]), 32'd1);
        clr[0] = 1'b0;
        #1;
        chk("arst_mdat", mdat[0], 32'd0);
        chk("arst_busy", 32'(bsy[0]), 32'd0);
        chk("arst_rdy", 32'(rdy[0]), 32'd0);
        chk("arst_err", 32'(er[0]), 32'd0);
        last_rd[0] = '0;
        repeat (2) @(negedge clk);
        clr[0] = 1'b1;
        req(0, 1'b1, 9'd5, 32'h0, LAT0, "rd5_after_rst");

        // Read held high for ten cycles: one access only.
        @(negedge clk);
        rd[0] = 1'b1; addr[0] = 9'd3;
        exp_q.push_back(model[0][3]);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rdy[0]) begin
                pulses++;
                sb_check(0, "held_data");
            end
        end
        chk("held_pulses", pulses, 1);
        chk("held_busy", 32'(bsy[0]), 32'd1);
        rd[0] = 1'b0;
        @(negedge clk);
        chk("held_release", 32'(bsy[0]), 32'd0);

        // Address moved from 3 to 4 during WAIT.
        @(negedge clk);
        rd[0] = 1'b1; addr[0] = 9'd3;
        exp_q.push_back(model[0][3]);
        @(negedge clk);
        rd[0] = 1'b0; addr[0] = 9'd4;
        pulses = 0;
        for (int i = 0; i < LAT0; i++) begin
            @(negedge clk);
            if (rdy[0]) begin
                pulses++;
                sb_check(0, "latched_data");
            end
        end
        chk("latched_pulses", pulses, 1);
        @(negedge clk);

        // Conflicting strobes.
        @(negedge clk);
        rd[0] = 1'b1; wr[0] = 1'b1; addr[0] = 9'h010; wdat[0] = 32'h0000_0BAD;
        @(negedge clk);
        chk("cf_err_k", 32'(er[0]), 32'd0);
        chk("cf_busy_k", 32'(bsy[0]), 32'd1);
        pulses = int'(rdy[0]);
        @(negedge clk);
        chk("cf_err_k1", 32'(er[0]), 32'd1);
        pulses += int'(rdy[0]);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("cf_err_once", 32'(er[0]), 32'd0);
            chk("cf_hold", 32'(bsy[0]), 32'd1);
            pulses += int'(rdy[0]);
        end
        rd[0] = 1'b0; wr[0] = 1'b0;
        @(negedge clk);
        chk("cf_release", 32'(bsy[0]), 32'd0);
        chk("cf_no_rdy", pulses, 0);
        req(0, 1'b1, 9'h010, 32'h0, LAT0, "cf_mem_kept");

        // Zero wait states on the second instance.
        req(1, 1'b0, 9'h1FF, 32'h0000_0018, LAT1, "z_wr");
        req(1, 1'b1, 9'h1FF, 32'h0, LAT1, "z_rd");
        req(1, 1'b1, 9'h1FF, 32'h0, LAT1, "z_rd2");

        chk("sb_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
